// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair.
//   rle_dec_st_t : decoder FSM states
//   grp2width    : active sample width in bits from the disabled-byte-group mask
//   flag_mask    : one-hot mask of the value/count flag bit for a given active width
package rle_pkg;

    localparam int unsigned MAX_KW = 32;
    localparam int unsigned MAX_DW = 8 * MAX_KW;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        REPEAT
    } rle_dec_st_t;

    // Enabled groups are contiguous from bit 0, so counting clear bits gives the width.
    function automatic int unsigned grp2width(input logic [MAX_KW-1:0] dis,
                                              input int unsigned         kw);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_KW; i++) begin
            if (i < kw && !dis[i]) begin
                n++;
            end
        end
        return 8 * n;
    endfunction

    function automatic logic [MAX_DW-1:0] flag_mask(input int unsigned w);
        logic [MAX_DW-1:0] m;
        m = '0;
        if (w != 0) begin
            m = {{(MAX_DW-1){1'b0}}, 1'b1} << (w - 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/rle_dec_if.sv
// Valid/ready stream pair for the RLE decoder.
//   sti_data/sti_valid/sti_ready : compressed input stream (value or count words)
//   sto_data/sto_valid/sto_ready : decoded sample stream
// Modports: slave = decoder side, master = producer/consumer side.
interface rle_dec_if #(
    parameter int unsigned DW = 32
);
    logic [DW-1:0] sti_data;
    logic          sti_valid;
    logic          sti_ready;
    logic [DW-1:0] sto_data;
    logic          sto_valid;
    logic          sto_ready;

    modport master (
        output sti_data, sti_valid, sto_ready,
        input  sti_ready, sto_data, sto_valid
    );

    modport slave (
        input  sti_data, sti_valid, sto_ready,
        output sti_ready, sto_data, sto_valid
    );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands value/count words back into one word per sample.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          1: decode, 0: forward every input word unchanged
//   disabledGroups  1 = byte group disabled (enabled groups contiguous from bit 0)
//   bus             rle_dec_if.slave: sti_* input stream, sto_* output stream
//   rle_err         sticky: count word seen with no value held
//   sto_cnt         samples emitted, saturating (only when RLE_DEC_CNT_EN is defined)
// Word format at active width W: bit W-1 clear = value, set = count of extra copies.
module rle_dec
    import rle_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [KW-1:0] disabledGroups,
    rle_dec_if.slave      bus,
    output logic          rle_err
`ifdef RLE_DEC_CNT_EN
    ,
    output logic [31:0]   sto_cnt
`endif
);

    rle_dec_st_t   state_q, state_d;
    logic [DW-1:0] held_q, held_d;
    logic [DW-2:0] rep_q, rep_d;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          err_q;

    int unsigned   act_w;
    logic [DW-1:0] flag, dmask, in_word, cnt_full;
    logic [DW-2:0] n_cnt;
    logic          is_cnt, load, accept;
    logic          emit, err_set;
    logic [DW-1:0] emit_data;

    // Decode the input word at the active width.
    always_comb begin
        act_w    = grp2width(MAX_KW'(disabledGroups), KW);
        flag     = DW'(flag_mask(act_w));
        // flag << 1 wraps to 0 at full width, so the subtraction yields all ones.
        dmask    = (act_w == 0) ? '0 : (flag << 1) - DW'(1);
        in_word  = bus.sti_data & dmask;
        is_cnt   = |(bus.sti_data & flag);
        cnt_full = in_word & ~flag;
        n_cnt    = cnt_full[DW-2:0];
    end

    assign load          = !valid_q || bus.sto_ready;
    assign bus.sti_ready = load && (state_q != REPEAT);
    assign accept        = bus.sti_valid && bus.sti_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        rep_d   = rep_q;
        if (!enable) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept && !is_cnt) begin
                        held_d  = in_word;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (!is_cnt) begin
                            held_d = in_word;
                        end else if (n_cnt != '0) begin
                            rep_d   = n_cnt;
                            state_d = REPEAT;
                        end
                    end
                end
                REPEAT: begin
                    if (load) begin
                        rep_d = rep_q - (DW-1)'(1);
                        if (rep_q == (DW-1)'(1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_data = held_q;
        err_set   = 1'b0;
        if (!enable) begin
            emit      = accept;
            emit_data = bus.sti_data;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        err_set   = is_cnt;
                        emit      = !is_cnt;
                        emit_data = in_word;
                    end
                end
                HOLD: begin
                    if (accept && !is_cnt) begin
                        emit      = 1'b1;
                        emit_data = in_word;
                    end
                end
                REPEAT: begin
                    emit = load;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= '0;
            rep_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            held_q <= held_d;
            rep_q  <= rep_d;
            if (load) begin
                valid_q <= emit;
                if (emit) begin
                    data_q <= emit_data;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.sto_data  = data_q;
    assign bus.sto_valid = valid_q;
    assign rle_err       = err_q;

`ifdef RLE_DEC_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (valid_q && bus.sto_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign sto_cnt = cnt_q;
`endif

endmodule
